// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// One bit per cycle: a shift-add multiplier and a restoring divider share one
// 2*WIDTH accumulator. Operands are converted to magnitudes on entry and
// sign-corrected in the FIX cycle.
// Optional build macro MULDIV_EARLY_EXIT_EN: multiplies leave RUN as soon as
// the unconsumed multiplier bits are all zero; FIX then shifts the
// accumulator into its final position.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_read,
    input  logic             hilo_sel,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hilo_data
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b, orig_a;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     hi, lo;

    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shifted, div_diff;
    logic [WIDTH-1:0]     div_rem;
    logic                 div_qbit;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_iter;
    logic                 mul_early;
    logic [2*WIDTH-1:0]   prod, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Two's-complement magnitude for signed ops, raw bits for unsigned ops.
    function automatic logic [WIDTH-1:0] magnitude(input logic is_signed,
                                                   input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] sx;
        sx = signed'(x);
        if (is_signed && sx < 0)
            return WIDTH'(-sx);
        return x;
    endfunction

    // Conditional negation of a single-width result.
    function automatic logic [WIDTH-1:0] neg_w(input logic en,
                                               input logic [WIDTH-1:0] x);
        return en ? -x : x;
    endfunction

    // Conditional negation of the double-width product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic en,
                                                  input logic [2*WIDTH-1:0] x);
        return en ? -x : x;
    endfunction

    // One datapath iteration and the FIX-cycle sign correction.
    always_comb begin
        mul_addend  = acc[0] ? mag_a : '0;
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        div_shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff    = div_shifted - {1'b0, mag_b};
        div_qbit    = ~div_diff[WIDTH];
        div_rem     = div_qbit ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
        if (is_div)
            acc_next = {div_rem, acc[WIDTH-2:0], div_qbit};
        else
            acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_EARLY_EXIT_EN
        // mag_b holds the not-yet-consumed multiplier bits during a multiply.
        mul_early = ~is_div && (mag_b[WIDTH-1:1] == '0);
        prod      = acc >> cnt;
`else
        mul_early = 1'b0;
        prod      = acc;
`endif
        last_iter = (cnt == '0) || mul_early;
        prod_fix  = neg_2w(sign_a ^ sign_b, prod);
        quo_fix   = neg_w(sign_a ^ sign_b, acc[WIDTH-1:0]);
        rem_fix   = neg_w(sign_a, acc[2*WIDTH-1:WIDTH]);
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush)
                    state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (flush)
                    state_next = IDLE;
                else if (last_iter)
                    state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                done       = ~flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        stall = busy & (hilo_read | start);
    end

    // Operand capture, iteration and HI/LO write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            orig_a      <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        cnt         <= CNT_W'(WIDTH - 1);
                        is_div      <= op[1];
                        sign_a      <= op[0] & operand_a[WIDTH-1];
                        sign_b      <= op[0] & operand_b[WIDTH-1];
                        mag_a       <= magnitude(op[0], operand_a);
                        mag_b       <= magnitude(op[0], operand_b);
                        orig_a      <= operand_a;
                        acc         <= {{WIDTH{1'b0}},
                                        op[1] ? magnitude(op[0], operand_a)
                                              : magnitude(op[0], operand_b)};
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc <= acc_next;
                        // An early exit keeps the count of skipped shifts for FIX.
                        if (!mul_early && cnt != '0)
                            cnt <= cnt - CNT_W'(1);
`ifdef MULDIV_EARLY_EXIT_EN
                        if (!is_div)
                            mag_b <= mag_b >> 1;
`endif
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (mag_b == '0) begin
                            hi          <= orig_a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hilo_data = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for muldiv_sequencer (default build).
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  operand_a, operand_b;
    logic          hilo_read, hilo_sel, flush;
    logic          busy, stall, done, div_by_zero;
    logic [W-1:0]  hilo_data;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            stall_cnt;
    logic [W-1:0]  rh, rl;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hilo_read  (hilo_read),
        .hilo_sel   (hilo_sel),
        .flush      (flush),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hilo_data  (hilo_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [W-1:0] hi_v, output logic [W-1:0] lo_v);
        hilo_sel = 1'b1;
        #1 hi_v = hilo_data;
        hilo_sel = 1'b0;
        #1 lo_v = hilo_data;
    endtask

    // Issue one op, check timing of done/busy and the final HI/LO/flag.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic exp_dz);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check({tag, " busy_c1"}, busy, 1'b1);
        check({tag, " dz_clear"}, div_by_zero, 1'b0);
        repeat (W - 1) tick();
        check({tag, " done_c32"}, done, 1'b0);
        tick();
        check({tag, " done_c33"}, done, 1'b1);
        tick();
        check({tag, " busy_c34"}, busy, 1'b0);
        read_hilo(rh, rl);
        check({tag, " hi"}, rh, exp_hi);
        check({tag, " lo"}, rl, exp_lo);
        check({tag, " dz"}, div_by_zero, exp_dz);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        hilo_read = 1'b0; hilo_sel = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 1'b0);
        check("rst stall", stall, 1'b0);
        check("rst done", done, 1'b0);
        check("rst dz", div_by_zero, 1'b0);
        read_hilo(rh, rl);
        check("rst hi", rh, 32'h0);
        check("rst lo", rl, 32'h0);
        reset = 1'b1;
        tick();

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("mult_min",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run_op("divu",      2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu_z",    2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);

        // flush and start together in IDLE: start is dropped, flag kept
        start = 1'b1; flush = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_start busy", busy, 1'b0);
        check("flush_start dz", div_by_zero, 1'b1);

        run_op("div_z",     2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

        // stall while HI/LO are read during an op, re-issued start ignored
        op = 2'b00; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        stall_cnt = 0;
        for (int c = 2; c <= 34; c++) begin
            tick();
            if (c == 3) begin hilo_read = 1'b1; hilo_sel = 1'b0; end
            if (c == 5) begin
                start = 1'b1; op = 2'b10; operand_a = 32'd100; operand_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            #1;
            if (c == 2) check("stall c2", stall, 1'b0);
            if (c == 5) check("stall restart", stall, 1'b1);
            if (c >= 3 && c <= 33 && stall) stall_cnt++;
            if (c == 33) check("stall done", done, 1'b1);
            if (c == 34) begin
                check("stall c34", stall, 1'b0);
                check("stall data", hilo_data, 32'd42);
                check("stall busy", busy, 1'b0);
            end
        end
        check("stall cycles", stall_cnt, 31);
        hilo_read = 1'b0;
        tick();
        check("restart dropped", busy, 1'b0);
        read_hilo(rh, rl);
        check("stall hi", rh, 32'h0);

        // 1628201331 * 805654952 = 0x12345678_12345678
        run_op("multu_pat", 2'b00, 32'd1628201331, 32'd805654952, 32'h12345678, 32'h12345678, 1'b0);

        // flush mid-RUN
        op = 2'b10; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        check("flush_run busy", busy, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        check("flush_run idle", busy, 1'b0);
        check("flush_run done", done, 1'b0);
        read_hilo(rh, rl);
        check("flush_run hi", rh, 32'h12345678);
        check("flush_run lo", rl, 32'h12345678);

        // flush in the FIX cycle suppresses the write and the done pulse
        op = 2'b00; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (W) tick();
        flush = 1'b1;
        #1;
        check("flush_fix done", done, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_fix idle", busy, 1'b0);
        read_hilo(rh, rl);
        check("flush_fix hi", rh, 32'h12345678);
        check("flush_fix lo", rl, 32'h12345678);

        // asynchronous reset mid-RUN
        op = 2'b00; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        hilo_read = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("arst busy", busy, 1'b0);
        check("arst stall", stall, 1'b0);
        check("arst done", done, 1'b0);
        check("arst dz", div_by_zero, 1'b0);
        read_hilo(rh, rl);
        check("arst hi", rh, 32'h0);
        check("arst lo", rl, 32'h0);
        hilo_read = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller that sits beside the execute stage ALU and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from EX and sequences a one-bit-per-cycle shift-add / restoring-divide datapath.
- Applies sign correction and writes HI/LO.
- Raises a pipeline stall when EX needs HI/LO, or issues a new mul/div, while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  EX presents a valid mul/div operation this cycle.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- operand_a  in  WIDTH  rs value (multiplicand / dividend).
- operand_b  in  WIDTH  rt value (multiplier / divisor).
- hilo_read  in  1  mfhi/mflo in EX this cycle.
- hilo_sel  in  1  0 selects LO, 1 selects HI.
- flush  in  1  cancel in-flight operation (branch/exception squash).
- busy  out  1  operation in flight (RUN or FIX).
- stall  out  1  hold IF/ID/EX this cycle.
- done  out  1  one-cycle pulse in the FIX cycle.
- div_by_zero  out  1  registered flag for the last completed divide.
- hilo_data  out  WIDTH  selected HI or LO, combinational from registers.

Behaviour:
- Reset (async, reset low):
  - State IDLE; HI, LO, counter, working registers = 0.
  - busy=0, done=0, div_by_zero=0, stall=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 and flush=0 at an edge: latch |a|, |b|, sign_a, sign_b, op; counter=WIDTH-1; go to RUN. Signed ops take two's-complement magnitude; unsigned ops take raw values.
  - Clear div_by_zero on that edge.
- RUN: one iteration per cycle.
  - Multiply: 2*WIDTH accumulator, conditional add of multiplicand, shift right.
  - Divide: restoring shift-subtract producing a quotient bit.
  - Counter decrements; RUN with counter==0 goes to FIX.
  - RUN lasts exactly WIDTH cycles.
- FIX: lasts one cycle; done=1.
  - MULT: negate the 2*WIDTH product if sign_a!=sign_b.
  - DIV: negate the quotient if sign_a!=sign_b; the remainder takes sign_a.
  - HI=upper/remainder, LO=lower/quotient, written at the edge ending FIX; then go to IDLE.
- Latency: start sampled at edge 0 gives RUN during cycles 1..WIDTH, FIX during cycle WIDTH+1, HI/LO visible from edge WIDTH+2.
- busy=1 in RUN and FIX.
- stall = busy & (hilo_read | start). A start while busy is ignored; EX holds it via stall and it is re-presented.
- hilo_read in IDLE: no stall; hilo_data reflects current HI/LO.
- Divide by zero (b==0, either divide op):
  - LO=all ones; HI=original operand_a (unsigned bit pattern).
  - div_by_zero=1 at the FIX edge.
  - Full RUN length still taken.
- DIV of -2^(WIDTH-1) by -1: LO=0x80000000, HI=0, no flag.
- flush=1 in RUN/FIX: go to IDLE at the next edge, HI/LO unchanged, no done, div_by_zero unchanged. A flush in the FIX cycle suppresses the HI/LO write.
- flush and start in the same IDLE cycle: flush wins; start discarded.
- Reset mid-operation: immediate return to reset values; in-flight result lost.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined:
  - Multiply ops leave RUN for FIX once the remaining unconsumed multiplier bits are all zero, then shift the accumulator into final position in FIX.
  - Minimum one RUN cycle.
  - Divide timing is unchanged.
  - Example: MULTU x*1 completes with FIX at cycle 2.
- Undefined: fixed WIDTH-cycle RUN for all ops; latency is exactly as above.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 33; HI=0xFFFFFFFE, LO=0x00000001; busy low at cycle 34.
- MULT 0xFFFFFFFD(-3)*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIVU 100/7 -> LO=14, HI=2; DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1; next start clears the flag.
- start MULTU 6*7, hilo_read (LO) at cycle 3:
  - stall=1 through cycle 33, 0 at cycle 34.
  - hilo_data=42 at cycle 34.
  - Second start at cycle 5 is ignored with stall=1.
- Prior HI=LO=0x12345678; start DIVU, flush at cycle 10 -> IDLE at cycle 11, no done, HI/LO still 0x12345678; reset low mid-RUN -> all outputs and HI/LO 0 immediately.
